// File: rtl/mul16_seq_ctrl.sv
// 16x16 unsigned sequential multiplier: one 8x8 array multiplier is reused over
// four cycles, with a valid/ready handshake on both the operand and product sides.

module array8 (
   input  logic [7:0]  i_a,
   input  logic [7:0]  i_b,
   output logic [15:0] o_c
);

   // Classic shift-and-add array: one row per multiplier bit.
   always_comb begin
      o_c = '0;
      for (int i = 0; i < 8; i++) begin
         if (i_b[i]) begin
            o_c = o_c + ({8'd0, i_a} << i);
         end
      end
   end

endmodule

module mul16_seq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] p,
   output logic        busy,
   output logic [7:0]  done_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [1:0]  r_step;
   logic [15:0] r_opA;
   logic [15:0] r_opB;
   logic [31:0] r_acc;
   logic [31:0] r_p;
   logic [7:0]  r_doneCnt;

   logic [7:0]  w_mulA;
   logic [7:0]  w_mulB;
   logic [15:0] w_mulC;
   logic [31:0] w_ppShifted;
   logic [31:0] w_accNext;

   // Step bit 0 picks the multiplicand half, bit 1 the multiplier half:
   // 0 -> aL*bL, 1 -> aH*bL, 2 -> aL*bH, 3 -> aH*bH.
   assign w_mulA = r_step[0] ? r_opA[15:8] : r_opA[7:0];
   assign w_mulB = r_step[1] ? r_opB[15:8] : r_opB[7:0];

   array8 u_array8 (
      .i_a (w_mulA),
      .i_b (w_mulB),
      .o_c (w_mulC)
   );

   always_comb begin
      w_ppShifted = {16'd0, w_mulC};
      case (r_step)
         2'd0:    w_ppShifted = {16'd0, w_mulC};
         2'd1,
         2'd2:    w_ppShifted = {8'd0, w_mulC, 8'd0};
         2'd3:    w_ppShifted = {w_mulC, 16'd0};
         default: w_ppShifted = {16'd0, w_mulC};
      endcase
   end

   assign w_accNext = r_acc + w_ppShifted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_nextState = MUL;
         MUL:     if (r_step == 2'd3) w_nextState = DONE;
         DONE:    if (out_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // The product register only changes on the final step, so p holds the
   // previous result through IDLE and MUL of the next operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_step    <= 2'd0;
         r_opA     <= '0;
         r_opB     <= '0;
         r_acc     <= '0;
         r_p       <= '0;
         r_doneCnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_opA  <= a;
                  r_opB  <= b;
                  r_acc  <= '0;
                  r_step <= 2'd0;
               end
            end
            MUL: begin
               r_acc  <= w_accNext;
               r_step <= r_step + 2'd1;
               if (r_step == 2'd3) begin
                  r_p <= w_accNext;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_doneCnt <= r_doneCnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign p        = r_p;
   assign done_cnt = r_doneCnt;

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Self-checking bench for mul16_seq_ctrl: a cycle-level behavioural model is
// compared against every output on each falling edge, plus directed literal checks.

module tb_mul16_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] p;
   logic        busy;
   logic [7:0]  done_cnt;

   int nCompared   = 0;
   int nMismatched = 0;
   bit checkEn     = 1'b0;

   mul16_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy),
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural model: an operation is "in flight" for four cycles after it
   // is taken, then the product a*b waits until the consumer takes it.
   bit          mBusy   = 1'b0;
   bit          mDone   = 1'b0;
   int          mRemain = 0;
   logic [31:0] mA      = '0;
   logic [31:0] mB      = '0;
   logic [31:0] mP      = '0;
   logic [7:0]  mCnt    = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mBusy = 1'b0; mDone = 1'b0; mRemain = 0;
         mA = '0; mB = '0; mP = '0; mCnt = '0;
      end else if (!mBusy) begin
         if (in_valid) begin
            mBusy = 1'b1; mRemain = 4; mA = {16'd0, a}; mB = {16'd0, b};
         end
      end else if (!mDone) begin
         mRemain = mRemain - 1;
         if (mRemain == 0) begin
            mDone = 1'b1;
            mP    = mA * mB;
         end
      end else if (out_ready) begin
         mBusy = 1'b0; mDone = 1'b0; mCnt = mCnt + 8'd1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("in_ready",  {31'd0, in_ready},  {31'd0, !mBusy});
         checkOutput("out_valid", {31'd0, out_valid}, {31'd0, mDone});
         checkOutput("busy",      {31'd0, busy},      {31'd0, mBusy});
         checkOutput("p",         p,                  mP);
         checkOutput("done_cnt",  {24'd0, done_cnt},  {24'd0, mCnt});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // One complete operation: offer operands, wait for acceptance, check the
   // four-cycle latency and the product, hold off the consumer, then consume.
   task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB,
                                input logic [31:0] expP, input int holdLow, input bit toggle);
      bit wasReady;
      int n;
      in_valid  = 1'b1;
      a         = opA;
      b         = opB;
      out_ready = (holdLow == 0);
      n = 0;
      do begin
         wasReady = in_ready;
         tick();
         n++;
      end while (!wasReady && n < 20);
      if (!wasReady) checkOutput("acceptTimeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
         if (toggle) begin
            in_valid = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
         end
         tick();
         n++;
      end
      checkOutput("latency", n, 32'd4);
      checkOutput("pLiteral", p, expP);
      for (int i = 0; i < holdLow; i++) begin
         if (toggle) begin
            in_valid = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
         end
         tick();
         checkOutput("inReadyHold", {31'd0, in_ready}, 32'd0);
      end
      if (holdLow > 0) checkOutput("pHeld", p, expP);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checkOutput("outValidCleared", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [7:0]  cntBefore;

      #3 rst = 1'b1;
      #1 checkEn = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("resetDoneCnt", {24'd0, done_cnt}, 32'd0);
      checkOutput("resetInReady", {31'd0, in_ready}, 32'd1);

      applyStimulus(16'h1234, 16'h5678, 32'h06260060, 0, 1'b0);
      checkOutput("doneCntFirst", {24'd0, done_cnt}, 32'd1);
      applyStimulus(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 1'b0);
      applyStimulus(16'h0000, 16'hBEEF, 32'h00000000, 0, 1'b0);
      cntBefore = done_cnt;
      applyStimulus(16'h00FF, 16'h0100, 32'h0000FF00, 10, 1'b1);
      checkOutput("singleConsume", {24'd0, done_cnt}, {24'd0, cntBefore + 8'd1});

      // Abort mid-operation: reset lands while step 2 is being processed.
      in_valid = 1'b1; a = 16'hFFFF; b = 16'h0002;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      checkOutput("rstInReady",  {31'd0, in_ready},  32'd1);
      checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
      checkOutput("rstBusy",     {31'd0, busy},      32'd0);
      checkOutput("rstP",        p,                  32'd0);
      checkOutput("rstDoneCnt",  {24'd0, done_cnt},  32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("noStaleValid", {31'd0, out_valid}, 32'd0);
      end
      applyStimulus(16'd3, 16'd5, 32'h0000000F, 0, 1'b0);

      // Fresh counter, then 257 operations so done_cnt wraps exactly once.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 257; i++) begin
         ra = 16'(i);
         rb = 16'(i + 1);
         applyStimulus(ra, rb, 32'(i) * 32'(i + 1), 0, 1'b0);
      end
      checkOutput("doneCntWrap", {24'd0, done_cnt}, 32'h01);

      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         applyStimulus(ra, rb, {16'd0, ra} * {16'd0, rb}, int'($urandom_range(0, 3)), 1'($urandom));
      end

      tick();
      checkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
